// File: rtl/shift_left_logical_seq.sv
// Multi-cycle logical left shifter: one binary stage (1,2,4,8,16) per clock, ready/valid on both sides.
// Optional build macro SHIFT_EARLY_DONE_EN ends the SHIFT phase once no higher shamt bits remain.
module shift_left_logical_seq #(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in,
  input  logic [SHW-1:0] shamt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] LAST_STAGE = SHW'(SHW - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   data_q, data_d;
  logic [SHW-1:0] amt_q, amt_d;
  logic [SHW-1:0] stage_q, stage_d;
  logic [SHW:0]   stage_dist;
  logic           last_stage;

  assign stage_dist = (SHW+1)'(1) << stage_q;

`ifdef SHIFT_EARLY_DONE_EN
  // Remaining shamt bits above the current stage; zero means nothing left to shift.
  logic [SHW-1:0] amt_upper;
  assign amt_upper  = amt_q >> ({1'b0, stage_q} + (SHW+1)'(1));
  assign last_stage = (stage_q == LAST_STAGE) || (amt_upper == '0);
`else
  assign last_stage = (stage_q == LAST_STAGE);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    stage_d = stage_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in;
          amt_d   = shamt;
          stage_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (amt_q[stage_q]) begin
          data_d = data_q << stage_dist;
        end
        stage_d = stage_q + SHW'(1);
        if (last_stage) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result comes straight from the data register, so out has no path from in/shamt.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out       = data_q;

endmodule

// File: tb/tb_shift_left_logical_seq.sv
// Self-checking bench for shift_left_logical_seq: directed vectors plus a queue-based reference model.
module tb_shift_left_logical_seq;

  localparam int N   = 32;
  localparam int SHW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [N-1:0]   operand = '0;
  logic [SHW-1:0] shamt = '0;
  logic           in_ready;
  logic           out_valid;
  logic [N-1:0]   result;
  logic           busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [N-1:0] value;
    int           due;
  } item_t;

  item_t pend[$];

  shift_left_logical_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (operand),
    .shamt    (shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  function automatic logic [N-1:0] model_shift(input logic [N-1:0] a, input int s);
    return a << s;
  endfunction

  function automatic int shift_edges(input int s);
`ifdef SHIFT_EARLY_DONE_EN
    for (int i = SHW - 1; i >= 0; i--) begin
      if (s[i]) return i + 1;
    end
    return 1;
`else
    return SHW;
`endif
  endfunction

  // Reference model: one pending result at a time, with the cycle it must first appear.
  always @(negedge clk) begin
    if (!rst) begin
      pend.delete();
      check_output("reset_in_ready", N'(in_ready), N'(1));
      check_output("reset_out_valid", N'(out_valid), N'(0));
      check_output("reset_out", result, '0);
      check_output("reset_busy", N'(busy), N'(0));
    end else begin
      check_output("ready_valid_exclusive", N'(in_ready && out_valid), N'(0));
      check_output("busy_vs_ready", N'(busy), N'(!in_ready));
      check_output("idle_iff_empty", N'(in_ready), N'(pend.size() == 0));
      if (pend.size() == 0) begin
        check_output("no_spurious_valid", N'(out_valid), N'(0));
      end else begin
        check_output("valid_timing", N'(out_valid), N'(cyc >= pend[0].due));
        if (out_valid) begin
          check_output("model_result", result, pend[0].value);
          if (out_ready) void'(pend.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        item_t it;
        it.value = model_shift(operand, int'(shamt));
        it.due   = cyc + 1 + shift_edges(int'(shamt));
        pend.push_back(it);
      end
    end
  end

  // Issue one operand, wait for its result, hold it for stall_cycles, then take it.
  task automatic apply_stimulus(input logic [N-1:0] a, input logic [SHW-1:0] s, input int stall_cycles,
                                input logic [N-1:0] expected, input string name, output int latency);
    int acc_cyc;
    int guard;
    latency = -1;
    operand  = a;
    shamt    = s;
    in_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 100);
    if (!in_ready) begin
      report_timeout({name, "_accept"});
      in_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!out_valid && guard < 100);
    if (!out_valid) begin
      report_timeout({name, "_result"});
      return;
    end
    latency = cyc - acc_cyc;
    check_output(name, result, expected);
    for (int i = 0; i < stall_cycles; i++) begin
      @(negedge clk);
      check_output({name, "_hold_out"}, result, expected);
      check_output({name, "_hold_valid"}, N'(out_valid), N'(1));
      check_output({name, "_hold_ready"}, N'(in_ready), N'(0));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int guard;
    logic [N-1:0] ra;
    logic [SHW-1:0] rs;

    #1;
    check_output("por_in_ready", N'(in_ready), N'(1));
    check_output("por_out_valid", N'(out_valid), N'(0));
    check_output("por_out", result, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    apply_stimulus(32'h0000_0001, 5'd31, 0, 32'h8000_0000, "shamt31", lat);
    check_output("shamt31_latency", N'(lat), N'(6));

    apply_stimulus(32'hDEAD_BEEF, 5'd0, 0, 32'hDEAD_BEEF, "shamt0", lat);
`ifdef SHIFT_EARLY_DONE_EN
    check_output("shamt0_latency", N'(lat), N'(2));
`else
    check_output("shamt0_latency", N'(lat), N'(6));
`endif

    apply_stimulus(32'hF0F0_F0F1, 5'd4, 10, 32'h0F0F_0F10, "stall_hold", lat);
    apply_stimulus(32'hA5A5_A5A5, 5'd16, 0, 32'hA5A5_0000, "shamt16", lat);
    apply_stimulus(32'hFFFF_FFFF, 5'd31, 1, 32'h8000_0000, "ones31", lat);
    apply_stimulus(32'h8000_0001, 5'd1, 2, 32'h0000_0002, "shamt1", lat);

    // in_valid stays high with a new operand while the first one is in flight.
    operand  = 32'h0000_00FF;
    shamt    = 5'd8;
    in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    operand = 32'h1234_5678;
    shamt   = 5'd4;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!out_valid && guard < 100);
    if (!out_valid) report_timeout("held_valid_first");
    check_output("held_valid_first", result, 32'h0000_FF00);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!busy && guard < 100);
    if (!busy) report_timeout("held_valid_second_accept");
    @(posedge clk);
    #1 in_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!out_valid && guard < 100);
    if (!out_valid) report_timeout("held_valid_second");
    check_output("held_valid_second", result, 32'h2345_6780);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Reset in the third SHIFT cycle aborts the operation.
    operand  = 32'hFFFF_FFFF;
    shamt    = 5'd31;
    in_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 100);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("abort_out_valid", N'(out_valid), N'(0));
    check_output("abort_out", result, '0);
    check_output("abort_in_ready", N'(in_ready), N'(1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    apply_stimulus(32'h0000_0003, 5'd2, 0, 32'h0000_000C, "after_reset", lat);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom();
      rs = SHW'($urandom_range(N - 1, 0));
      apply_stimulus(ra, rs, $urandom_range(3, 0), model_shift(ra, int'(rs)), "sweep", lat);
    end

    repeat (3) @(posedge clk);
    #1;
    check_output("drained", N'(pend.size()), N'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
